// File: rtl/bcd_down_timer_pkg.sv
// bcd_down_timer_pkg
// Shared definitions for the two-digit BCD down timer.
//   state_t     : timer FSM state encoding (IDLE/RUN/PAUSE/EXPIRED)
//   DIGIT_W     : width of one BCD digit
//   BCD_MAX     : largest legal BCD digit value
//   clamp_digit : saturates an out-of-range digit (>9) to 9
package bcd_down_timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if
// Command/status bundle of the BCD down timer.
//   load, load_val, start, stop, tick : commands from the controller (master)
//   cnt, busy, done                   : registered status from the timer (slave)
// Handshake: there is no valid/ready pair. Every command is a level sampled
// on each rising clk edge; the timer always accepts it in that same cycle and
// the resulting status is visible after that edge. Priority among commands
// sampled on one edge is load > stop > start > tick.
interface bcd_down_timer_if;

  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       stop;
  logic       tick;
  logic [7:0] cnt;
  logic       busy;
  logic       done;

  modport master (
    output load, load_val, start, stop, tick,
    input  cnt, busy, done
  );

  modport slave (
    input  load, load_val, start, stop, tick,
    output cnt, busy, done
  );

endinterface

// File: rtl/bcd_down_digit.sv
// bcd_down_digit
// One registered BCD digit that counts down.
//   clk, rst_n : clock, synchronous active-low reset (digit -> 0)
//   load       : loads clamp_digit(load_digit); wins over dec_en
//   load_digit : value to load (values above 9 are clamped to 9)
//   dec_en     : decrement by one this edge, wrapping 0 -> 9
//   digit      : current digit value
//   borrow     : high when dec_en is asserted while the digit is 0, i.e. the
//                wrap to 9 borrows from the next digit up
module bcd_down_digit
  import bcd_down_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               dec_en,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow
);

  logic [DIGIT_W-1:0] digit_q;

  // Borrow depends only on dec_en and the stored digit, never on load, so a
  // parent may derive its load from the borrow chain without a loop.
  assign borrow = dec_en && (digit_q == '0);
  assign digit  = digit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else if (load) begin
      digit_q <= clamp_digit(load_digit);
    end else if (dec_en) begin
      digit_q <= (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// bcd_down_timer
// Two-digit BCD countdown timer with start/stop/load control.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset (IDLE, cnt 00, busy/done 0)
//   bus       : bcd_down_timer_if.slave (load, load_val, start, stop, tick
//               in; cnt, busy, done out, all outputs registered)
//   dbg_state : current FSM state for observation
// Optional feature macro: BCD_TIMER_AUTORELOAD_EN. When defined, every load
// also stores the clamped value in a reload register and a tick at cnt 01
// in RUN reloads that value, pulses done and stays in RUN. When undefined,
// the same tick takes cnt to 00, pulses done and parks in EXPIRED.
module bcd_down_timer
  import bcd_down_timer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_down_timer_if.slave         bus,
  output state_t                  dbg_state
);

  state_t st;
  logic   busy_q;
  logic   done_q;

  logic [DIGIT_W-1:0] units_q;
  logic [DIGIT_W-1:0] tens_q;
  logic               units_borrow;
  logic               tens_borrow;

  logic       dec;
  logic       at_one;
  logic       cnt_nz;
  logic       expire;
  logic       dig_load;
  logic [7:0] dig_val;

  assign at_one = (tens_q == '0) && (units_q == 4'd1);
  assign cnt_nz = (tens_q != '0) || (units_q != '0);

  // A counting tick: RUN state, no stop or load competing on this edge.
  assign dec = (st == RUN) && bus.tick && !bus.stop && !bus.load;

  // tens_borrow can only fire if the pair were decremented from 00, which
  // the FSM never allows; it is folded into expiry so the count can never
  // wrap to 99.
  assign expire = dec && (at_one || tens_borrow);

`ifdef BCD_TIMER_AUTORELOAD_EN
  logic [7:0] reload_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reload_q <= 8'h00;
    end else if (bus.load) begin
      reload_q <= {clamp_digit(bus.load_val[7:4]), clamp_digit(bus.load_val[3:0])};
    end
  end

  // Expiry overwrites the decrement with the stored period.
  assign dig_load = bus.load || expire;
  assign dig_val  = bus.load ? bus.load_val : reload_q;
`else
  // At 01 the normal decrement already lands on 00; only the (unreachable)
  // underflow case needs an explicit clear.
  assign dig_load = bus.load || (dec && tens_borrow);
  assign dig_val  = bus.load ? bus.load_val : 8'h00;
`endif

  bcd_down_digit u_units (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (dig_load),
    .load_digit (dig_val[3:0]),
    .dec_en     (dec),
    .digit      (units_q),
    .borrow     (units_borrow)
  );

  bcd_down_digit u_tens (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (dig_load),
    .load_digit (dig_val[7:4]),
    .dec_en     (units_borrow),
    .digit      (tens_q),
    .borrow     (tens_borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        st     <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            // start with stop acts as stop, which IDLE ignores
            if (bus.start && !bus.stop && cnt_nz) begin
              st     <= RUN;
              busy_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.stop) begin
              st <= PAUSE;
            end else if (expire) begin
              done_q <= 1'b1;
`ifndef BCD_TIMER_AUTORELOAD_EN
              st     <= EXPIRED;
              busy_q <= 1'b0;
`endif
            end
          end
          PAUSE: begin
            if (bus.start && !bus.stop) begin
              st <= RUN;
            end
          end
          EXPIRED: begin
            st <= EXPIRED;
          end
          default: begin
            st     <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cnt   = {tens_q, units_q};
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign dbg_state = st;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer
// Directed bench for bcd_down_timer. Each step drives one cycle of commands
// and queues the hand-computed {state, busy, done, cnt} expected after the
// next rising edge; a monitor pops and compares after every edge.
// Honors BCD_TIMER_AUTORELOAD_EN to select which expiry behaviour to expect.
module tb_bcd_down_timer;
  import bcd_down_timer_pkg::*;

  localparam int W = 12;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  bcd_down_timer_if bus ();

  bcd_down_timer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           checks = 0;
  int           errors = 0;
  int           step_id = 0;

  always @(posedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    int           id;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      id    = id_q.pop_front();
      got_v = {dbg_state, bus.busy, bus.done, bus.cnt};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL step%0d: got state=%0d busy=%b done=%b cnt=%h, expected state=%0d busy=%b done=%b cnt=%h",
                 id, got_v[11:10], got_v[9], got_v[8], got_v[7:0],
                 exp_v[11:10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
  end

  // driver
  task automatic step(input logic l, input logic [7:0] lv, input logic s,
                      input logic sp, input logic t, input logic r,
                      input logic [7:0] ec, input logic eb, input logic ed,
                      input state_t es);
    @(negedge clk);
    bus.load     = l;
    bus.load_val = lv;
    bus.start    = s;
    bus.stop     = sp;
    bus.tick     = t;
    rst_n        = r;
    step_id++;
    exp_q.push_back({es, eb, ed, ec});
    id_q.push_back(step_id);
  endtask

  task automatic tick_exp(input logic [7:0] ec, input logic eb, input logic ed,
                          input state_t es);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, ec, eb, ed, es);
  endtask

  logic [7:0] seq12 [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                             8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] seq_ar [9] = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03,
                             8'h02, 8'h01, 8'h03};

  initial begin
    bus.load = 1'b0; bus.load_val = 8'h00; bus.start = 1'b0;
    bus.stop = 1'b0; bus.tick = 1'b0; rst_n = 1'b0;

    // reset with load pending: reset wins
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, IDLE);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, IDLE);

`ifndef BCD_TIMER_AUTORELOAD_EN
    // countdown 12 -> 00
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, IDLE);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, RUN);
    for (int i = 0; i < 12; i++) begin
      if (i == 11) tick_exp(seq12[i], 1'b0, 1'b1, EXPIRED);
      else         tick_exp(seq12[i], 1'b1, 1'b0, RUN);
    end
    // done was one cycle; EXPIRED ignores start and tick
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, EXPIRED);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, EXPIRED);
    tick_exp(8'h00, 1'b0, 1'b0, EXPIRED);

    // pause
    step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, IDLE);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, RUN);
    tick_exp(8'h04, 1'b1, 1'b0, RUN);
    tick_exp(8'h03, 1'b1, 1'b0, RUN);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, PAUSE);
    for (int i = 0; i < 3; i++) tick_exp(8'h03, 1'b1, 1'b0, PAUSE);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, RUN);
    tick_exp(8'h02, 1'b1, 1'b0, RUN);
    tick_exp(8'h01, 1'b1, 1'b0, RUN);
    tick_exp(8'h00, 1'b0, 1'b1, EXPIRED);
`else
    // auto-reload, period 3
    step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, IDLE);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, RUN);
    for (int i = 0; i < 9; i++) begin
      tick_exp(seq_ar[i], 1'b1, (i % 3 == 2) ? 1'b1 : 1'b0, RUN);
    end
    // reload value 01: done on every tick, stop still pauses
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, IDLE);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, RUN);
    tick_exp(8'h01, 1'b1, 1'b1, RUN);
    tick_exp(8'h01, 1'b1, 1'b1, RUN);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, PAUSE);
`endif

    // clamp with load beating start; start at 00 ignored
    step(1'b1, 8'hAF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, IDLE);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, IDLE);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, IDLE);

    // start+stop in IDLE acts as stop; tick in IDLE ignored; borrow 40 -> 39
    step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0, IDLE);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0, IDLE);
    tick_exp(8'h40, 1'b0, 1'b0, IDLE);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, RUN);
    tick_exp(8'h39, 1'b1, 1'b0, RUN);

    // load mid-run with a tick: load wins, no decrement
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, IDLE);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, RUN);
    tick_exp(8'h01, 1'b1, 1'b0, RUN);
    step(1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0, IDLE);

    // abort: reset with tick at cnt 01 in RUN
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, IDLE);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, RUN);
    tick_exp(8'h01, 1'b1, 1'b0, RUN);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, IDLE);
    tick_exp(8'h00, 1'b0, 1'b0, IDLE);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous reset, active-low.
REQ-004 load  input  1  loads load_val into cnt; highest-priority command.
REQ-005 load_val  input  8  preset value: [7:4] tens BCD digit, [3:0] units BCD digit.
REQ-006 start  input  1  begins or resumes countdown.
REQ-007 stop  input  1  pauses countdown.
REQ-008 tick  input  1  one-cycle count enable; one decrement per tick.
REQ-009 cnt  output  8  current count: [7:4] tens BCD digit, [3:0] units BCD digit.
REQ-010 busy  output  1  high in RUN and PAUSE.
REQ-011 done  output  1  one-cycle pulse on expiry.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, PAUSE, EXPIRED.
REQ-013 Load digits >9 SHALL be clamped to 9 per digit, e.g. load_val 8'hA3 -> cnt 8'h93.
REQ-014 load in any state SHALL set cnt = clamped load_val, go to IDLE, and suppress done, one cycle later.
REQ-015 Command priority SHALL be load > stop > start > tick.
REQ-016 IDLE + start with cnt != 00 SHALL go to RUN; start with cnt == 00 is ignored.
REQ-017 RUN + stop SHALL go to PAUSE; PAUSE + start SHALL go to RUN; stop in PAUSE/IDLE/EXPIRED is ignored.
REQ-018 Simultaneous start and stop SHALL act as stop.
REQ-019 RUN + tick (no stop/load) SHALL decrement cnt by one in BCD on the next edge.
REQ-020 A units digit of 0 SHALL wrap to 9 and borrow one from tens, e.g. 8'h40 -> 8'h39.
REQ-021 RUN + tick with cnt == 01 SHALL set cnt = 00, pulse done for exactly one cycle on the same edge, and go to EXPIRED.
REQ-022 tick in IDLE, PAUSE or EXPIRED SHALL be ignored.
REQ-023 EXPIRED SHALL hold cnt = 00 and ignore start; only load or reset leaves it.
REQ-024 A tick coincident with stop SHALL NOT decrement.
REQ-025 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-026 rst_n low at a clk edge SHALL force IDLE, cnt = 8'h00, busy = 0, done = 0, reload register = 8'h00.
REQ-027 Reset mid-RUN SHALL abandon the count with no done pulse.
REQ-028 Reset SHALL override all inputs on the same edge.

Configuration
REQ-029 The macro BCD_TIMER_AUTORELOAD_EN SHALL select auto-reload.
REQ-030 With BCD_TIMER_AUTORELOAD_EN defined:
- Each load also stores the clamped value in a reload register.
- RUN + tick at cnt == 01 sets cnt = reload value, pulses done and stays in RUN.
- cnt never shows 00 in RUN; the period is N ticks.
- A reload value of 01 gives a done pulse on every tick.
REQ-031 Without BCD_TIMER_AUTORELOAD_EN, REQ-021 and REQ-023 apply and the reload register is absent.

Structure
REQ-032 A shared package SHALL hold:
- the state enum (IDLE/RUN/PAUSE/EXPIRED);
- BCD_MAX = 4'd9;
- the digit width constant.
REQ-033 A single-digit sub-module bcd_down_digit SHALL implement the per-digit logic:
- inputs: load, load digit, decrement enable;
- outputs: digit, borrow-out at 0 -> 9 wrap;
- two instances are chained through borrow.

Verification
REQ-034 Reset: rst_n = 0 for 2 cycles with load = 1, load_val = 8'h55 -> cnt = 00, busy = 0, done = 0.
REQ-035 Countdown: load 8'h12, start, 12 ticks -> sequence 12,11,10,09,...,01,00, one done pulse on the 12th tick, state EXPIRED, busy = 0.
REQ-036 Pause: load 8'h05, start, 2 ticks, stop together with a tick, 3 ticks, start, 3 ticks -> cnt 03 held through pause, ends 00 with done.
REQ-037 Clamp and priority: load 8'hAF together with start -> cnt = 8'h99 in IDLE; start with cnt = 00 -> stays IDLE.
REQ-038 Auto-reload (macro defined): load 8'h03, start, 9 ticks -> done on ticks 3, 6 and 9, cnt back to 03, busy stays 1.
REQ-039 Abort: reset asserted at cnt = 8'h01 in RUN together with a tick -> cnt = 00, no done pulse, state IDLE.
